uart_cfg_core: RTL and testbench

UART_CFG_CORE -- requirements
Module: uart_cfg_core

---
 rtl/uart_cfg_core.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_cfg_core.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_cfg_core
// Purpose  : Parameterised UART transmitter/receiver (5-8 data bits, parity, 1-2 stop).
// Revision : 1.0
// ============================================================================
module uart_cfg_core #(
    parameter int SCYCLE   = 50_000_000,
    parameter int BAUDRATE = 9600,
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       TX,
    input  logic [7:0] TXDATA,
    input  logic       TXSTART,
    output logic       TXBUSY,
    output logic       TXDONE,
    input  logic       RX,
    output logic [7:0] RXDATA,
    output logic       RXBUSY,
    output logic       RXDONE,
    output logic       RXPERR,
    output logic       RXFERR
);

    localparam int DIV = SCYCLE / BAUDRATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BIT_END   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(DIV / 2 - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATABITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOPBITS - 1);
    localparam logic [7:0]    DMASK     = 8'((1 << DATABITS) - 1);
    localparam bit            HAS_PAR   = (PARITY != 0);

    if (DATABITS < 5 || DATABITS > 8 || STOPBITS < 1 || STOPBITS > 2 ||
        PARITY < 0 || PARITY > 2 || DIV < 4) begin : g_param_check
        $error("uart_cfg_core: illegal DATABITS/STOPBITS/PARITY or DIV < 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // ---------------- transmitter ----------------
    state_t          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_par_q, tx_par_d;
    logic            tx_q, tx_d;
    logic            tx_done_q, tx_done_d;
    logic [7:0]      w_tx_word;
    logic            w_tx_bit_end;

    assign w_tx_word    = TXDATA & DMASK;
    assign w_tx_bit_end = (tx_cnt_q == BIT_END);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        if (tx_state_q != ST_IDLE) begin
            tx_cnt_d = w_tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (TXSTART) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = w_tx_word;
                    tx_par_d   = (PARITY == 1) ? ~^w_tx_word : ^w_tx_word;
                    tx_d       = 1'b0;
                end
            end
            ST_START: if (w_tx_bit_end) begin
                tx_state_d = ST_DATA;
                tx_idx_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            ST_DATA: if (w_tx_bit_end) begin
                if (tx_idx_q == DATA_LAST) begin
                    tx_idx_d   = '0;
                    tx_state_d = HAS_PAR ? ST_PAR : ST_STOP;
                    tx_d       = HAS_PAR ? tx_par_q : 1'b1;
                end else begin
                    // Shift after each bit so the next bit is always at [1]
                    tx_idx_d   = tx_idx_q + 3'd1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end
            end
            ST_PAR: if (w_tx_bit_end) begin
                tx_state_d = ST_STOP;
                tx_idx_d   = '0;
                tx_d       = 1'b1;
            end
            ST_STOP: if (w_tx_bit_end) begin
                if (tx_idx_q == STOP_LAST) begin
                    tx_state_d = ST_IDLE;
                    tx_done_d  = 1'b1;
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX     = tx_q;
    assign TXBUSY = (tx_state_q != ST_IDLE);
    assign TXDONE = tx_done_q;

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    state_t          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_acc_q, rx_acc_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_perr_q, rx_perr_d;
    logic            rx_ferr_q, rx_ferr_d;
    logic            rx_done_q, rx_done_d;
    logic            w_rx_fall;
    logic            w_rx_bit_end;

    // A low stop sample leaves rx_prev_q low, so no new start until the line rises
    assign w_rx_fall    = rx_prev_q & ~rx_sync_q;
    assign w_rx_bit_end = (rx_cnt_q == BIT_END);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_acc_d   = rx_acc_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_done_d  = 1'b0;
        case (rx_state_q)
            ST_IDLE: if (w_rx_fall) begin
                rx_state_d = ST_START;
                rx_cnt_d   = '0;
            end
            ST_START: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_acc_d   = 1'b0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                rx_cnt_d = w_rx_bit_end ? '0 : rx_cnt_q + 1'b1;
                if (w_rx_bit_end) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_acc_d   = rx_acc_q ^ rx_sync_q;
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == DATA_LAST) begin
                        rx_state_d = HAS_PAR ? ST_PAR : ST_STOP;
                    end
                end
            end
            ST_PAR: begin
                rx_cnt_d = w_rx_bit_end ? '0 : rx_cnt_q + 1'b1;
                if (w_rx_bit_end) begin
                    rx_acc_d   = rx_acc_q ^ rx_sync_q;
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                rx_cnt_d = w_rx_bit_end ? '0 : rx_cnt_q + 1'b1;
                if (w_rx_bit_end) begin
                    rx_data_d  = rx_shift_q >> (8 - DATABITS);
                    rx_perr_d  = (PARITY == 1) ? ~rx_acc_q :
                                 (PARITY == 2) ?  rx_acc_q : 1'b0;
                    rx_ferr_d  = ~rx_sync_q;
                    rx_done_d  = 1'b1;
                    rx_state_d = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_acc_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_acc_q   <= rx_acc_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_done_q  <= rx_done_d;
        end
    end

    assign RXDATA = rx_data_q;
    assign RXBUSY = (rx_state_q != ST_IDLE);
    assign RXDONE = rx_done_q;
    assign RXPERR = rx_perr_q;
    assign RXFERR = rx_ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_cfg_core
// Purpose  : Scoreboard bench for uart_cfg_core in 8N1, 7E2 loopback and 8O1 setups.
// Revision : 1.0
// ============================================================================
module tb_uart_cfg_core;

    localparam int NBITS_8N1 = 10;
    localparam int FRAME_8N1 = NBITS_8N1 * 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rx_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // 8N1 instance
    logic       tx_n, txbusy_n, txdone_n, rxbusy_n, rxdone_n, rxperr_n, rxferr_n;
    logic [7:0] txdata_n = 8'h00, rxdata_n;
    logic       txstart_n = 1'b0, rx_n = 1'b1;
    // 7E2 instance, TX looped to RX
    logic       tx_e, txbusy_e, txdone_e, rxbusy_e, rxdone_e, rxperr_e, rxferr_e;
    logic [7:0] txdata_e = 8'h00, rxdata_e;
    logic       txstart_e = 1'b0;
    // 8O1 instance, RX driven directly
    logic       tx_o, txbusy_o, txdone_o, rxbusy_o, rxdone_o, rxperr_o, rxferr_o;
    logic [7:0] txdata_o = 8'h00, rxdata_o;
    logic       txstart_o = 1'b0, rx_o = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_tx[$];
    rx_t        q_n[$], q_e[$], q_o[$];
    int         exp_done_n = 0;
    int         done_cnt_n = 0;
    int         done_cnt_o = 0;
    logic [7:0] last_rx_n  = 8'h00;

    always #5 clk = ~clk;

    uart_cfg_core #(.SCYCLE(1600), .BAUDRATE(100), .DATABITS(8), .PARITY(0), .STOPBITS(1)) u_n (
        .CLK(clk), .RESET(rst), .TX(tx_n), .TXDATA(txdata_n), .TXSTART(txstart_n),
        .TXBUSY(txbusy_n), .TXDONE(txdone_n), .RX(rx_n), .RXDATA(rxdata_n),
        .RXBUSY(rxbusy_n), .RXDONE(rxdone_n), .RXPERR(rxperr_n), .RXFERR(rxferr_n));

    uart_cfg_core #(.SCYCLE(1600), .BAUDRATE(100), .DATABITS(7), .PARITY(2), .STOPBITS(2)) u_e (
        .CLK(clk), .RESET(rst), .TX(tx_e), .TXDATA(txdata_e), .TXSTART(txstart_e),
        .TXBUSY(txbusy_e), .TXDONE(txdone_e), .RX(tx_e), .RXDATA(rxdata_e),
        .RXBUSY(rxbusy_e), .RXDONE(rxdone_e), .RXPERR(rxperr_e), .RXFERR(rxferr_e));

    uart_cfg_core #(.SCYCLE(1600), .BAUDRATE(100), .DATABITS(8), .PARITY(1), .STOPBITS(1)) u_o (
        .CLK(clk), .RESET(rst), .TX(tx_o), .TXDATA(txdata_o), .TXSTART(txstart_o),
        .TXBUSY(txbusy_o), .TXDONE(txdone_o), .RX(rx_o), .RXDATA(rxdata_o),
        .RXBUSY(rxbusy_o), .RXDONE(rxdone_o), .RXPERR(rxperr_o), .RXFERR(rxferr_o));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event with no expected entry", name);
    endtask

    // par < 0 means no parity bit; bit k of the frame is held 16 cycles
    task automatic drive_rx(input bit on_o, input logic [7:0] d, input int nd,
                            input int par, input logic stop);
        logic [11:0] b;
        int          n;
        b = '0;
        n = 1;
        for (int i = 0; i < nd; i++) begin
            b[n] = d[i];
            n++;
        end
        if (par >= 0) begin
            b[n] = par[0];
            n++;
        end
        b[n] = stop;
        n++;
        for (int k = 0; k < n; k++) begin
            if (on_o) rx_o = b[k];
            else      rx_n = b[k];
            repeat (16) @(negedge clk);
        end
    endtask

    // ---------------- monitors ----------------
    initial forever begin : mon_rx_n
        rx_t en;
        @(negedge clk);
        if (!rst && rxdone_n) begin
            if (q_n.size() == 0) flag("rx_n_spurious_rxdone");
            else begin
                en = q_n.pop_front();
                check("rx_n_word", {rxdata_n, rxperr_n, rxferr_n}, {en.d, en.pe, en.fe});
            end
        end
    end

    initial forever begin : mon_rx_e
        rx_t ee;
        @(negedge clk);
        if (!rst && rxdone_e) begin
            if (q_e.size() == 0) flag("rx_e_spurious_rxdone");
            else begin
                ee = q_e.pop_front();
                check("rx_e_word", {rxdata_e, rxperr_e, rxferr_e}, {ee.d, ee.pe, ee.fe});
            end
        end
    end

    initial forever begin : mon_rx_o
        rx_t eo;
        @(negedge clk);
        if (!rst && rxdone_o) begin
            if (q_o.size() == 0) flag("rx_o_spurious_rxdone");
            else begin
                eo = q_o.pop_front();
                check("rx_o_word", {rxdata_o, rxperr_o, rxferr_o}, {eo.d, eo.pe, eo.fe});
            end
        end
        if (!rst && txdone_o) done_cnt_o++;
    end

    // Captures every cycle of an 8N1 frame on tx_n and compares against the ideal waveform
    initial forever begin : mon_tx_n
        logic [FRAME_8N1-1:0] cap;
        logic [7:0]           exp_b, dec;
        logic                 want;
        int                   cap_n, mism;
        bit                   cap_on;
        logic                 tx_prev;
        cap     = '0;
        cap_n   = 0;
        cap_on  = 1'b0;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap_on = 1'b0;
                cap_n  = 0;
            end else if (!cap_on) begin
                if (tx_prev && !tx_n) begin
                    cap_on = 1'b1;
                    cap[0] = tx_n;
                    cap_n  = 1;
                end
            end else begin
                cap[cap_n] = tx_n;
                cap_n++;
                if (cap_n == FRAME_8N1) begin
                    cap_on = 1'b0;
                    if (q_tx.size() == 0) flag("tx_n_spurious_frame");
                    else begin
                        exp_b = q_tx.pop_front();
                        mism  = 0;
                        for (int i = 0; i < FRAME_8N1; i++) begin
                            if (i / 16 == 0)      want = 1'b0;
                            else if (i / 16 == 9) want = 1'b1;
                            else                  want = exp_b[i / 16 - 1];
                            if (cap[i] !== want) mism++;
                        end
                        for (int b = 0; b < 8; b++) dec[b] = cap[(b + 1) * 16 + 8];
                        check("tx_n_data", dec, exp_b);
                        check("tx_n_bit_timing_mismatches", mism, 0);
                    end
                end
            end
            tx_prev = tx_n;
        end
    end

    initial forever begin : mon_txbusy_n
        int   run;
        logic busy_prev;
        run       = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (txbusy_n) run++;
                else if (run != 0) begin
                    check("txbusy_n_length", run, FRAME_8N1);
                    run = 0;
                end
                if (txdone_n) begin
                    done_cnt_n++;
                    check("txdone_n_first_idle_cycle", {busy_prev, txbusy_n}, 2'b10);
                end
            end
            busy_prev = txbusy_n;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int         k;
        int         busy_seen;
        logic [9:0] fb;

        #2 rst = 1'b1;
        #1;
        check("reset_n_flags", {tx_n, txbusy_n, txdone_n, rxbusy_n, rxdone_n, rxperr_n, rxferr_n},
              7'b1000000);
        check("reset_n_rxdata", rxdata_n, 8'h00);
        check("reset_o_flags", {tx_o, txbusy_o, rxbusy_o, rxperr_o, rxferr_o}, 5'b10000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 single frame 0xA5
        @(negedge clk);
        txdata_n  = 8'hA5;
        txstart_n = 1'b1;
        q_tx.push_back(8'hA5);
        exp_done_n++;
        @(negedge clk);
        txstart_n = 1'b0;
        check("tx_n_start_bit_after_accept", {tx_n, txbusy_n}, 2'b01);
        txdata_n = 8'hFF;
        repeat (200) @(negedge clk);

        // 7E2 loopback, second frame requested in the TXDONE cycle
        @(negedge clk);
        txdata_e  = 8'h53;
        txstart_e = 1'b1;
        q_e.push_back('{d: 8'h53, pe: 1'b0, fe: 1'b0});
        @(negedge clk);
        txdata_e = 8'h2A;
        k = 0;
        while (!txdone_e && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!txdone_e) begin
            $display("FAIL e_txdone_timeout: no TXDONE within 400 cycles");
            n_tests++;
            n_fail++;
        end
        q_e.push_back('{d: 8'h2A, pe: 1'b0, fe: 1'b0});
        check("e_tx_high_in_txdone_cycle", tx_e, 1'b1);
        @(negedge clk);
        txstart_e = 1'b0;
        check("e_back_to_back_no_gap", {tx_e, txbusy_e}, 2'b01);
        repeat (400) @(negedge clk);

        // 8O1 receive: bad parity, bad stop held low, then a clean frame
        q_o.push_back('{d: 8'h00, pe: 1'b1, fe: 1'b0});
        drive_rx(1'b1, 8'h00, 8, 0, 1'b1);
        q_o.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
        drive_rx(1'b1, 8'h00, 8, 1, 1'b0);
        repeat (40) @(negedge clk);
        rx_o = 1'b1;
        repeat (20) @(negedge clk);
        q_o.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0});
        drive_rx(1'b1, 8'hC3, 8, 1, 1'b1);
        repeat (40) @(negedge clk);

        // TXSTART held high: each frame takes TXDATA from its own acceptance cycle
        for (int c = 0; c <= 322; c++) begin
            @(negedge clk);
            txdata_n  = 8'(c * 37 + 11);
            txstart_n = 1'b1;
            if (c == 0 || c == 161 || c == 322) q_tx.push_back(8'(c * 37 + 11));
        end
        @(negedge clk);
        txstart_n = 1'b0;
        exp_done_n += 3;
        repeat (250) @(negedge clk);

        // Reset 70 cycles into simultaneous TX and RX frames on the 8N1 instance
        fb = {1'b1, 8'h5A, 1'b0};
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c == 0) begin
                txdata_n  = 8'h3C;
                txstart_n = 1'b1;
            end
            if (c == 1) txstart_n = 1'b0;
            rx_n = fb[c / 16];
        end
        #1 rst = 1'b1;
        #1;
        check("midframe_reset_flags", {tx_n, txbusy_n, txdone_n, rxbusy_n, rxdone_n}, 5'b10000);
        check("midframe_reset_rxdata", rxdata_n, 8'h00);
        rx_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        @(negedge clk);
        txdata_n  = 8'h81;
        txstart_n = 1'b1;
        q_tx.push_back(8'h81);
        exp_done_n++;
        q_n.push_back('{d: 8'h6E, pe: 1'b0, fe: 1'b0});
        last_rx_n = 8'h6E;
        fork
            begin
                @(negedge clk);
                txstart_n = 1'b0;
            end
            drive_rx(1'b0, 8'h6E, 8, -1, 1'b1);
        join
        repeat (100) @(negedge clk);

        // 5-cycle low glitch must be rejected
        busy_seen = 0;
        @(negedge clk);
        rx_n = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 4) rx_n = 1'b1;
            if (rxbusy_n) busy_seen++;
        end
        check("glitch_rxbusy_pulsed", (busy_seen > 0 && busy_seen < 16), 1'b1);
        check("glitch_rxdata_held", rxdata_n, last_rx_n);

        // Drain and final idle checks
        k = 0;
        while ((q_tx.size() + q_n.size() + q_e.size() + q_o.size()) != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("pending_tx_n_frames", q_tx.size(), 0);
        check("pending_rx_n_words", q_n.size(), 0);
        check("pending_rx_e_words", q_e.size(), 0);
        check("pending_rx_o_words", q_o.size(), 0);
        check("txdone_n_count", done_cnt_n, exp_done_n);
        check("o_tx_never_used", {tx_o, txbusy_o, done_cnt_o[0]}, 3'b100);
        check("all_idle_at_end", {txbusy_n, txbusy_e, rxbusy_n, rxbusy_e, rxbusy_o}, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
